sprite_frame_sequencer: RTL and testbench



---
 rtl/sprite_frame_sequencer_if.sv | 11 +
 rtl/sprite_frame_sequencer.sv | 178 +++++++++++++++++
 tb/tb_sprite_frame_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_frame_sequencer_if.sv
// CPU write port (Avalon-style) between the processor bus and the sprite sequencer.
// The master drives writes; the sequencer only listens.
interface sprite_frame_sequencer_if;
   logic        chipselect;
   logic        write;
   logic [3:0]  address;
   logic [31:0] writedata;

   modport master (output chipselect, output write, output address, output writedata);
   modport slave  (input  chipselect, input  write, input  address, input  writedata);
endinterface

// File: rtl/sprite_frame_sequencer.sv
// Double-buffered sprite register bank: CPU writes land in shadows and are committed
// to the active set at the start of vertical blank; also sequences the run animation.
module sprite_frame_sequencer #(
   parameter int HACTIVE    = 1280,
   parameter int VACTIVE    = 480,
   parameter int ANIM_RESET = 6
) (
   input  logic                   clk,
   input  logic                   reset_n,
   sprite_frame_sequencer_if.slave bus,
   input  logic [10:0]            hcount,
   input  logic [9:0]             vcount,
   output logic [7:0]             dino_x,
   output logic [7:0]             dino_y,
   output logic [7:0]             jump_x,
   output logic [7:0]             jump_y,
   output logic [7:0]             duck_x,
   output logic [7:0]             duck_y,
   output logic [7:0]             scac_x,
   output logic [7:0]             scac_y,
   output logic [7:0]             godzilla_x,
   output logic [7:0]             godzilla_y,
   output logic [7:0]             score_x,
   output logic [7:0]             score_y,
   output logic [3:0]             score,
   output logic [1:0]             sprite_state,
   output logic                   frame_tick,
   output logic [15:0]            frame_count,
   output logic                   pending
);

   localparam int         NumPos  = 12;
   localparam logic [9:0] VCommit = 10'(VACTIVE);

   typedef enum logic [1:0] {RUN0 = 2'd0, RUN1 = 2'd1, RUN2 = 2'd2} animState_e;

   function automatic logic [7:0] posResetVal(input int idx);
      logic [7:0] v;
      case (idx)
         0, 1, 7, 8: v = 8'd100;
         2, 5:       v = 8'd200;
         3:          v = 8'd150;
         4:          v = 8'd44;
         6:          v = 8'd244;
         9:          v = 8'd4;
         10:         v = 8'd225;
         11:         v = 8'd185;
         default:    v = 8'd0;
      endcase
      return v;
   endfunction

   logic [7:0]  shadowPos_q [NumPos];
   logic [7:0]  shadowPos_d [NumPos];
   logic [7:0]  activePos_q [NumPos];
   logic [7:0]  activePos_d [NumPos];
   logic [3:0]  shadowScore_q, shadowScore_d;
   logic [3:0]  activeScore_q, activeScore_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic        pending_q, pending_d;
   logic        frameTick_q;
   logic [15:0] frameCount_q;
   logic [7:0]  animPeriod_q;
   logic [7:0]  animCnt_q;
   animState_e  state_q;

   logic wrEn, commitPt, forceCommit, doCommit;
   logic posWrite, scoreWrite, periodWrite, ctrlWrite;
   logic unusedWdataHi;

   // A zero-width line has no first pixel, so it can never reach the commit point.
   assign commitPt    = (HACTIVE > 0) && (hcount == 11'd0) && (vcount == VCommit);
   assign wrEn        = bus.chipselect && bus.write;
   assign posWrite    = wrEn && (bus.address < 4'd12);
   assign scoreWrite  = wrEn && (bus.address == 4'd12);
   assign periodWrite = wrEn && (bus.address == 4'd13);
   assign ctrlWrite   = wrEn && (bus.address == 4'd14);
   assign forceCommit = wrEn && (bus.address == 4'd15);
   assign doCommit    = (commitPt && !ctrl_q[1]) || forceCommit;

   assign unusedWdataHi = ^bus.writedata[31:8];

   // Commit copies the pre-write shadows; a same-cycle write still lands afterwards.
   always_comb begin
      shadowPos_d   = shadowPos_q;
      activePos_d   = activePos_q;
      shadowScore_d = shadowScore_q;
      activeScore_d = activeScore_q;
      ctrl_d        = ctrl_q;
      pending_d     = pending_q;

      if (doCommit) begin
         activePos_d   = shadowPos_q;
         activeScore_d = shadowScore_q;
         pending_d     = 1'b0;
      end
      for (int i = 0; i < NumPos; i++) begin
         if (posWrite && (bus.address == 4'(i))) begin
            shadowPos_d[i] = bus.writedata[7:0];
            if (ctrl_q[0]) activePos_d[i] = bus.writedata[7:0];
         end
      end
      if (scoreWrite) begin
         shadowScore_d = bus.writedata[3:0];
         if (ctrl_q[0]) activeScore_d = bus.writedata[3:0];
      end
      if ((posWrite || scoreWrite) && !ctrl_q[0]) pending_d = 1'b1;
      if (ctrlWrite) ctrl_d = bus.writedata[1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NumPos; i++) begin
            shadowPos_q[i] <= posResetVal(i);
            activePos_q[i] <= posResetVal(i);
         end
         shadowScore_q <= 4'd0;
         activeScore_q <= 4'd0;
         ctrl_q        <= 2'd0;
         pending_q     <= 1'b0;
         frameTick_q   <= 1'b0;
         frameCount_q  <= 16'd0;
      end else begin
         shadowPos_q   <= shadowPos_d;
         activePos_q   <= activePos_d;
         shadowScore_q <= shadowScore_d;
         activeScore_q <= activeScore_d;
         ctrl_q        <= ctrl_d;
         pending_q     <= pending_d;
         frameTick_q   <= commitPt;
         frameCount_q  <= commitPt ? frameCount_q + 16'd1 : frameCount_q;
      end
   end

   // Writing the period restarts the count and takes priority over a coincident tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= RUN0;
         animCnt_q    <= 8'd0;
         animPeriod_q <= 8'(ANIM_RESET);
      end else if (periodWrite) begin
         animPeriod_q <= bus.writedata[7:0];
         animCnt_q    <= 8'd0;
      end else if (commitPt) begin
         if (animPeriod_q == 8'd0) begin
            animCnt_q <= 8'd0;
         end else if (animCnt_q == animPeriod_q - 8'd1) begin
            animCnt_q <= 8'd0;
            case (state_q)
               RUN0:    state_q <= RUN1;
               RUN1:    state_q <= RUN2;
               default: state_q <= RUN0;
            endcase
         end else begin
            animCnt_q <= animCnt_q + 8'd1;
         end
      end
   end

   assign dino_x       = activePos_q[0];
   assign dino_y       = activePos_q[1];
   assign jump_x       = activePos_q[2];
   assign jump_y       = activePos_q[3];
   assign duck_x       = activePos_q[4];
   assign duck_y       = activePos_q[5];
   assign scac_x       = activePos_q[6];
   assign scac_y       = activePos_q[7];
   assign godzilla_x   = activePos_q[8];
   assign godzilla_y   = activePos_q[9];
   assign score_x      = activePos_q[10];
   assign score_y      = activePos_q[11];
   assign score        = activeScore_q;
   assign sprite_state = state_q;
   assign frame_tick   = frameTick_q;
   assign frame_count  = frameCount_q;
   assign pending      = pending_q;

endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// Scoreboard bench for sprite_frame_sequencer: stimulus queues expected snapshots,
// a negedge monitor pops them on every frame_tick and every explicit probe.
module tb_sprite_frame_sequencer;

   typedef struct {
      string       name;
      logic [7:0]  dinoX;
      logic [7:0]  jumpY;
      logic [7:0]  godX;
      logic [7:0]  scoreY;
      logic [3:0]  score;
      logic [1:0]  state;
      logic [15:0] fc;
      logic        pend;
   } snap_t;

   logic clk;
   logic reset_n;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [7:0]  dino_x, dino_y, jump_x, jump_y, duck_x, duck_y;
   logic [7:0]  scac_x, scac_y, godzilla_x, godzilla_y, score_x, score_y;
   logic [3:0]  score;
   logic [1:0]  sprite_state;
   logic        frame_tick;
   logic [15:0] frame_count;
   logic        pending;

   sprite_frame_sequencer_if bus();

   sprite_frame_sequencer #(.HACTIVE(1280), .VACTIVE(480), .ANIM_RESET(6)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bus          (bus),
      .hcount       (hcount),
      .vcount       (vcount),
      .dino_x       (dino_x),
      .dino_y       (dino_y),
      .jump_x       (jump_x),
      .jump_y       (jump_y),
      .duck_x       (duck_x),
      .duck_y       (duck_y),
      .scac_x       (scac_x),
      .scac_y       (scac_y),
      .godzilla_x   (godzilla_x),
      .godzilla_y   (godzilla_y),
      .score_x      (score_x),
      .score_y      (score_y),
      .score        (score),
      .sprite_state (sprite_state),
      .frame_tick   (frame_tick),
      .frame_count  (frame_count),
      .pending      (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   snap_t tickQ[$];
   snap_t probeQ[$];
   snap_t monSnap;
   logic  probeReq;
   int    testsRun = 0;
   int    failures = 0;

   logic [7:0]  eDinoX, eJumpY, eGodX, eScoreY;
   logic [3:0]  eScore;
   logic [1:0]  eState;
   logic [15:0] eFc;
   logic        ePend;
   logic [1:0]  animExp [8];

   function automatic snap_t makeSnap(input string name);
      snap_t s;
      s.name = name;  s.dinoX = eDinoX; s.jumpY = eJumpY; s.godX = eGodX;
      s.scoreY = eScoreY; s.score = eScore; s.state = eState; s.fc = eFc; s.pend = ePend;
      return s;
   endfunction

   task automatic resetModel();
      eDinoX = 8'd100; eJumpY = 8'd150; eGodX = 8'd100; eScoreY = 8'd185;
      eScore = 4'd0;   eState = 2'd0;   eFc = 16'd0;    ePend = 1'b0;
   endtask

   task automatic cmp(input string tag, input string field, input int act, input int exp);
      testsRun++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s.%s: got %0d, expected %0d", tag, field, act, exp);
      end
   endtask

   task automatic compareSnap(input snap_t s);
      cmp(s.name, "dino_x",       int'(dino_x),       int'(s.dinoX));
      cmp(s.name, "jump_y",       int'(jump_y),       int'(s.jumpY));
      cmp(s.name, "godzilla_x",   int'(godzilla_x),   int'(s.godX));
      cmp(s.name, "score_y",      int'(score_y),      int'(s.scoreY));
      cmp(s.name, "score",        int'(score),        int'(s.score));
      cmp(s.name, "sprite_state", int'(sprite_state), int'(s.state));
      cmp(s.name, "frame_count",  int'(frame_count),  int'(s.fc));
      cmp(s.name, "pending",      int'(pending),      int'(s.pend));
   endtask

   // Monitor: every frame_tick must match a queued commit, every probe a queued snapshot.
   always @(negedge clk) begin
      if (frame_tick) begin
         if (tickQ.size() == 0) begin
            testsRun++; failures++;
            $display("[TB] FAIL unexpected_tick: frame_tick=1, expected 0");
         end else begin
            monSnap = tickQ.pop_front();
            compareSnap(monSnap);
         end
      end
      if (probeReq) begin
         if (probeQ.size() == 0) begin
            testsRun++; failures++;
            $display("[TB] FAIL probe_underflow: probe with no queued expectation");
         end else begin
            monSnap = probeQ.pop_front();
            compareSnap(monSnap);
         end
      end
   end

   task automatic applyStimulus(input logic [10:0] hc, input logic [9:0] vc, input logic cs,
                                input logic wr, input logic [3:0] addr, input logic [31:0] data);
      @(posedge clk); #1;
      probeReq       = 1'b0;
      hcount         = hc;
      vcount         = vc;
      bus.chipselect = cs;
      bus.write      = wr;
      bus.address    = addr;
      bus.writedata  = data;
   endtask

   task automatic idle();
      applyStimulus(11'd300, 10'd100, 1'b0, 1'b0, 4'd0, 32'd0);
   endtask

   task automatic writeReg(input logic [3:0] addr, input logic [31:0] data);
      applyStimulus(11'd300, 10'd100, 1'b1, 1'b1, addr, data);
   endtask

   task automatic commit(input string name);
      tickQ.push_back(makeSnap(name));
      applyStimulus(11'd0, 10'd480, 1'b0, 1'b0, 4'd0, 32'd0);
   endtask

   task automatic writeOnCommit(input string name, input logic [3:0] addr, input logic [31:0] data);
      tickQ.push_back(makeSnap(name));
      applyStimulus(11'd0, 10'd480, 1'b1, 1'b1, addr, data);
   endtask

   task automatic checkOutput(input string name);
      applyStimulus(11'd300, 10'd100, 1'b0, 1'b0, 4'd0, 32'd0);
      probeReq = 1'b1;
      probeQ.push_back(makeSnap(name));
   endtask

   initial begin
      animExp = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1};
      probeReq = 1'b0;
      reset_n = 1'b0;
      hcount = 11'd600; vcount = 10'd200;
      bus.chipselect = 1'b0; bus.write = 1'b0; bus.address = 4'd0; bus.writedata = 32'd0;
      resetModel();
      #23 reset_n = 1'b1;
      checkOutput("reset");

      // Shadowed write holds until the commit point; near misses must not commit.
      writeReg(4'd0, 32'd55);
      ePend = 1'b1;
      checkOutput("shadow_hold");
      applyStimulus(11'd1, 10'd480, 1'b0, 1'b0, 4'd0, 32'd0);
      applyStimulus(11'd0, 10'd479, 1'b0, 1'b0, 4'd0, 32'd0);
      applyStimulus(11'd300, 10'd100, 1'b0, 1'b1, 4'd0, 32'd99);
      applyStimulus(11'd300, 10'd100, 1'b1, 1'b0, 4'd0, 32'd88);
      checkOutput("near_miss");
      eDinoX = 8'd55; ePend = 1'b0; eFc = 16'd1;
      commit("commit1");
      checkOutput("after_commit1");

      // Write on the commit cycle: commit takes the old shadow, pending survives.
      eFc = 16'd2; ePend = 1'b1;
      writeOnCommit("collide", 4'd3, 32'd77);
      checkOutput("collide_after");
      eJumpY = 8'd77; ePend = 1'b0; eFc = 16'd3;
      commit("collide_next");

      // Hold suppresses commits but not ticks; force commit ignores hold.
      writeReg(4'd14, 32'd2);
      writeReg(4'd12, 32'd9);
      ePend = 1'b1;
      eFc = 16'd4; commit("hold1");
      idle();
      eFc = 16'd5; commit("hold2");
      checkOutput("hold_after");
      writeReg(4'd15, 32'hDEAD_BEEF);
      eScore = 4'd9; ePend = 1'b0;
      checkOutput("force");
      writeReg(4'd14, 32'd0);

      // Animation with period 2, then frozen at period 0.
      writeReg(4'd13, 32'd2);
      for (int i = 0; i < 8; i++) begin
         eFc++; eState = animExp[i];
         commit("anim");
         idle();
      end
      writeReg(4'd13, 32'd0);
      for (int i = 0; i < 5; i++) begin
         eFc++;
         commit("freeze");
         idle();
      end
      eFc++;
      writeOnCommit("period_clear", 4'd13, 32'd1);
      idle();
      eFc++; eState = 2'd2;
      commit("period1_step");

      // Immediate mode updates active and shadow together without pending.
      writeReg(4'd14, 32'd1);
      writeReg(4'd8, 32'd12);
      eGodX = 8'd12;
      checkOutput("immediate");
      writeReg(4'd14, 32'd0);
      eFc++; eState = 2'd0;
      commit("imm_shadow");
      writeReg(4'd0, 32'd33);
      ePend = 1'b1;
      checkOutput("pre_reset");

      // Asynchronous reset mid-frame, then a normal commit afterwards.
      @(posedge clk); #3;
      probeReq = 1'b0;
      reset_n = 1'b0;
      resetModel();
      checkOutput("async_reset");
      @(negedge clk); #1;
      reset_n = 1'b1;
      idle();
      eFc = 16'd1;
      commit("post_reset_commit");
      idle();
      checkOutput("post_reset");
      repeat (3) idle();

      cmp("end", "tick_queue_left",  tickQ.size(),  0);
      cmp("end", "probe_queue_left", probeQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
